data_ram_pipe: RTL and testbench
================================

// Module: data_ram_pipe
// PURPOSE
//  Parametrised single-port data RAM: successor to the 16x256 async-read data memory.
//  Valid/ready request port; read data returned after a fixed, registered RD_LAT pipeline.
//  After every reset, a hardware clear sweep zeroes the array.
//  Sits between the core's load/store stage and the data address space.
// PARAMETERS
//  DATA_W    16  data word width in bits (multiple of 8)
//  ADDR_W     8  address width; depth = 2**ADDR_W words
//  RD_LAT     1  read latency in cycles, legal range 1..4
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   1             request present
//  req_ready  out  1             block accepts request this cycle
//  req_we     in   1             1 = write, 0 = read
//  req_addr   in   ADDR_W        word address
//  req_wdata  in   DATA_W        write data
//  req_be     in   DATA_W/8      byte enables (used only with DATA_RAM_BE_EN)
//  rsp_valid  out  1             read data valid, one-cycle pulse per read
//  rsp_rdata  out  DATA_W        read data
//  busy       out  1             clear sweep in progress
// BEHAVIOUR
//  - Accept: req_valid & req_ready at a rising edge. At most one op per cycle.
//  - Reset values (rst_n low): req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0.
//    Reset clears the read pipeline and clear_ptr; array contents are not reset.
//  - FSM states:
//    - CLEAR (entered on reset):
//      - Each cycle writes 0 to mem[clear_ptr]; clear_ptr++.
//      - After writing 2**ADDR_W-1, next state is RUN.
//      - Sweep takes exactly 2**ADDR_W cycles after rst_n rises.
//    - RUN: req_ready=1, busy=0. No exit except reset.
//  - Reset asserted mid-sweep or mid-read:
//    - In-flight reads are dropped; no rsp_valid is issued for them.
//    - The sweep restarts from address 0.
//  - Write: on the accept edge, mem[req_addr] <= req_wdata. Produces no response.
//  - Read:
//    - Array sampled on the accept edge, then delayed RD_LAT-1 further register stages.
//    - rsp_valid is high in cycle N+RD_LAT for a read accepted in cycle N.
//  - Ordering:
//    - Write in cycle N, read of same address in cycle N+1 -> returns the new data.
//    - Read in cycle N, write of same address in cycle N+1 -> returns the old data.
//  - Back-to-back reads: one per cycle, fully pipelined. Responses come in order, no bubbles.
//  - rsp_rdata holds its last value while rsp_valid=0. It is never driven Z.
//  - Requests with req_valid while busy are ignored. The requester must hold them until req_ready.
//  - Addresses cover the full 2**ADDR_W range; no out-of-range case exists.
//  - Read pipeline: RD_LAT-deep shift of {valid, data}. No backpressure on the response side.
// CONFIGURATION
//  DATA_RAM_BE_EN defined:
//    - Write updates only bytes with req_be[i]=1; other bytes keep their old value.
//    - req_be=0 makes a write a no-op.
//    - The clear sweep writes all bytes.
//  DATA_RAM_BE_EN undefined:
//    - req_be is ignored and every write updates the full word.
// TESTING
//  1 Reset, ADDR_W=8:
//    - busy=1 and req_ready=0 for 256 cycles after rst_n rises, then busy=0, req_ready=1.
//    - Read of every address returns 0.
//  2 RD_LAT=3, write 0xBEEF @0x10, next cycle read 0x10:
//    - rsp_valid pulses exactly 3 cycles after the read is accepted, rsp_rdata=0xBEEF.
//  3 Back-to-back reads of 0x01,0x02,0x03 preloaded 0x1111,0x2222,0x3333:
//    - rsp_valid high 3 consecutive cycles, data in order.
//  4 Read 0x20 (holds 0x0005) then write 0x0009 @0x20 next cycle:
//    - Response is 0x0005.
//    - A subsequent read of 0x20 returns 0x0009.
//  5 Pull rst_n low while 2 reads are in flight and at clear_ptr=0x80:
//    - No rsp_valid appears.
//    - Sweep restarts at 0 and lasts 256 cycles.
//  6 DATA_RAM_BE_EN, mem[0x30]=0x1234, write 0xABCD with req_be=2'b01:
//    - Read of 0x30 returns 0x12CD.
//    - Without the macro it returns 0xABCD.

Source files
------------

// File: rtl/data_ram_pipe.sv
// Single-port data RAM with valid/ready requests, RD_LAT-cycle registered read path
// and a zeroing sweep after reset. Define DATA_RAM_BE_EN to enable per-byte write enables.
module data_ram_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [RD_LAT-1:0]   rd_vld_q;
  logic [DATA_W-1:0]   rd_dat_q [RD_LAT];

  logic                acc, rd_acc, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    req_ready   = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        busy        = 1'b1;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == {ADDR_W{1'b1}}) state_d = S_RUN;
      end
      S_RUN:   req_ready = 1'b1;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  assign acc    = req_valid & req_ready;
  assign rd_acc = acc & ~req_we;

  // The sweep owns the single write port until it finishes.
  assign mem_we    = busy | (acc & req_we);
  assign mem_addr  = busy ? clear_ptr_q : req_addr;
  assign mem_wdata = busy ? '0 : req_wdata;

`ifdef DATA_RAM_BE_EN
  assign mem_be = busy ? '1 : req_be;
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign mem_be    = '1;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Data stages only advance with a valid token so the output holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= rd_acc;
      if (rd_acc) rd_dat_q[0] <= mem_q[req_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        if (rd_vld_q[i-1]) rd_dat_q[i] <= rd_dat_q[i-1];
      end
    end
  end

  assign rsp_valid = rd_vld_q[RD_LAT-1];
  assign rsp_rdata = rd_dat_q[RD_LAT-1];

endmodule

// File: tb/tb_data_ram_pipe.sv
// Randomized bench for data_ram_pipe against an array/queue reference model.
module tb_data_ram_pipe;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;

  always #5 clk = ~clk;

  data_ram_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          clear_edges = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] last_rdata = '0;
  exp_t        exp_q [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // The model's notion of the sweep: busy for DEPTH edges after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) clear_edges <= 0;
    else if (clear_edges < DEPTH) clear_edges <= clear_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic logic model_busy();
    return (!rst_n) || (clear_edges < DEPTH);
  endfunction

  task automatic check_outputs();
    logic ev;
    check("busy", 32'(busy), 32'(model_busy()));
    check("req_ready", 32'(req_ready), 32'(!model_busy()));
    ev = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      last_rdata = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    check_outputs();
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    if (v && !model_busy()) begin
      if (!we) begin
        exp_q.push_back('{edge_cnt + RD_LAT, ref_mem[a]});
      end else begin
`ifdef DATA_RAM_BE_EN
        for (int b = 0; b < 2; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
`else
        ref_mem[a] = d;
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    last_rdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (busy && n < 400);
    check("sweep_cycles", 32'(n), 32'(DEPTH));
  endtask

  task automatic random_ops(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), a, 16'($urandom), 2'($urandom));
    end
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    do_reset();
    wait_sweep();

    // write then read same address next cycle
    drive(1, 1, 8'h10, 16'hBEEF, 2'b11);
    drive(1, 0, 8'h10, 16'h0000, 2'b00);
    idle(RD_LAT + 1);

    // back-to-back reads
    drive(1, 1, 8'h01, 16'h1111, 2'b11);
    drive(1, 1, 8'h02, 16'h2222, 2'b11);
    drive(1, 1, 8'h03, 16'h3333, 2'b11);
    drive(1, 0, 8'h01, 16'h0000, 2'b00);
    drive(1, 0, 8'h02, 16'h0000, 2'b00);
    drive(1, 0, 8'h03, 16'h0000, 2'b00);
    idle(RD_LAT + 1);

    // read followed by write to the same address
    drive(1, 1, 8'h20, 16'h0005, 2'b11);
    idle(1);
    drive(1, 0, 8'h20, 16'h0000, 2'b00);
    drive(1, 1, 8'h20, 16'h0009, 2'b11);
    drive(1, 0, 8'h20, 16'h0000, 2'b00);
    idle(RD_LAT + 1);

    // partial byte writes
    drive(1, 1, 8'h30, 16'h1234, 2'b11);
    drive(1, 1, 8'h30, 16'hABCD, 2'b01);
    drive(1, 0, 8'h30, 16'h0000, 2'b00);
    drive(1, 1, 8'h31, 16'h5678, 2'b11);
    drive(1, 1, 8'h31, 16'h9999, 2'b00);
    drive(1, 0, 8'h31, 16'h0000, 2'b00);
    drive(1, 1, 8'h32, 16'h4321, 2'b10);
    drive(1, 0, 8'h32, 16'h0000, 2'b00);
    idle(RD_LAT + 1);

    random_ops(1500);

    // reset with two reads in flight
    drive(1, 0, 8'h01, 16'h0000, 2'b00);
    drive(1, 0, 8'h02, 16'h0000, 2'b00);
    do_reset();
    wait_sweep();
    random_ops(300);

    // reset halfway through the sweep
    do_reset();
    idle(128);
    do_reset();
    wait_sweep();

    for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(i), 16'h0000, 2'b00);
    idle(RD_LAT + 1);

    random_ops(500);
    idle(RD_LAT + 2);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
